stego_message_extractor: RTL and testbench

Recovers a hidden message from a stream of audio samples in which a message embedder has replaced the LSB of each sample with one message bit, MSB first, repeating cyclically. The block sits on the receive side of the sample path, fed by the UART-to-sample assembler or an I2S sample receiver. It reassembles `MESSAGE_LENGTH` bits and presents the completed word with a one-cycle valid pulse. It also passes every sample through with one cycle of latency so the downstream FIFO path is unchanged.

---
 rtl/stego_pkg.sv | 15 +
 rtl/stego_message_extractor_if.sv | 45 ++++
 rtl/stego_bit_collector.sv | 58 +++++
 rtl/stego_message_extractor.sv | 103 ++++++++++
 tb/tb_stego_message_extractor.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stego_pkg.sv
// Shared constants and state type for the steganographic message extractor and embedder.
package stego_pkg;

    localparam int unsigned BPS_DEFAULT            = 24;
    localparam int unsigned MESSAGE_LENGTH_DEFAULT = 88;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EMIT
    } stego_state_t;

    localparam logic [87:0] DEFAULT_MESSAGE = 88'h4B6F6368616D5A414D5046;

endpackage

// File: rtl/stego_message_extractor_if.sv
// Sample-path bundle for stego_message_extractor: the source drives in_*, the extractor drives out_*.
// The in_expected/out_match pair exists only when STEGO_MATCH_EN is defined.
interface stego_message_extractor_if
    import stego_pkg::*;
#(
    parameter int unsigned BPS            = BPS_DEFAULT,
    parameter int unsigned MESSAGE_LENGTH = MESSAGE_LENGTH_DEFAULT
);

    localparam int unsigned CountWidth = $clog2(MESSAGE_LENGTH + 1);

    logic                      in_enable;
    logic [BPS-1:0]            in_frame;
    logic                      in_resync;
    logic [BPS-1:0]            out_frame;
    logic                      out_ready;
    logic [MESSAGE_LENGTH-1:0] out_message;
    logic                      out_message_valid;
    logic [CountWidth-1:0]     out_bit_count;
`ifdef STEGO_MATCH_EN
    logic [MESSAGE_LENGTH-1:0] in_expected;
    logic                      out_match;

    modport master (
        output in_enable, in_frame, in_resync, in_expected,
        input  out_frame, out_ready, out_message, out_message_valid, out_bit_count, out_match
    );

    modport slave (
        input  in_enable, in_frame, in_resync, in_expected,
        output out_frame, out_ready, out_message, out_message_valid, out_bit_count, out_match
    );
`else
    modport master (
        output in_enable, in_frame, in_resync,
        input  out_frame, out_ready, out_message, out_message_valid, out_bit_count
    );

    modport slave (
        input  in_enable, in_frame, in_resync,
        output out_frame, out_ready, out_message, out_message_valid, out_bit_count
    );
`endif

endinterface

// File: rtl/stego_bit_collector.sv
// Shift register and bit counter for message reassembly; the counter wraps after the last bit,
// and clears on resync or on an external realign request.
module stego_bit_collector #(
    parameter int unsigned MESSAGE_LENGTH = 88
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    enable_i,
    input  logic                                    bit_i,
    input  logic                                    clear_i,
    input  logic                                    realign_i,
    output logic [MESSAGE_LENGTH-1:0]               shift_d_o,
    output logic [$clog2(MESSAGE_LENGTH + 1)-1:0]   count_o,
    output logic                                    wrap_o
);

    localparam int unsigned CountWidth = $clog2(MESSAGE_LENGTH + 1);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(MESSAGE_LENGTH - 1);

    logic [MESSAGE_LENGTH-1:0] shift_q, shift_d;
    logic [CountWidth-1:0]     count_q, count_d;

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        wrap_o  = 1'b0;
        if (clear_i) begin
            // A sample arriving with resync is kept as the first bit of the new message.
            shift_d = {{(MESSAGE_LENGTH - 1){1'b0}}, bit_i & enable_i};
            count_d = {{(CountWidth - 1){1'b0}}, enable_i};
        end else if (enable_i) begin
            shift_d = {shift_q[MESSAGE_LENGTH-2:0], bit_i};
            if (count_q == LastCount) begin
                wrap_o  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
            if (realign_i) begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign shift_d_o = shift_d;
    assign count_o   = count_q;

endmodule

// File: rtl/stego_message_extractor.sv
// Recovers an LSB-embedded message from the sample stream and passes samples through unchanged.
// Define STEGO_MATCH_EN to add the expected-message comparator that realigns message boundaries.
module stego_message_extractor
    import stego_pkg::*;
#(
    parameter int unsigned BPS            = BPS_DEFAULT,
    parameter int unsigned MESSAGE_LENGTH = MESSAGE_LENGTH_DEFAULT
) (
    input logic                      in_clk,
    input logic                      in_reset_n,
    stego_message_extractor_if.slave bus
);

    stego_state_t              state_q;
    logic [BPS-1:0]            frame_q;
    logic                      ready_q;
    logic [MESSAGE_LENGTH-1:0] message_q;
    logic                      valid_q;

    logic                      accept;
    logic [MESSAGE_LENGTH-1:0] shift_d;
    logic                      wrap;
    logic                      realign;

    assign accept = bus.in_enable;

`ifdef STEGO_MATCH_EN
    logic match;
    logic match_q;

    // Compare includes the bit arriving this cycle; resync cycles restart alignment instead.
    assign match   = accept && !bus.in_resync && (shift_d == bus.in_expected);
    assign realign = match;
    assign bus.out_match = match_q;
`else
    assign realign = 1'b0;
`endif

    stego_bit_collector #(
        .MESSAGE_LENGTH (MESSAGE_LENGTH)
    ) u_collector (
        .clk_i     (in_clk),
        .rst_ni    (in_reset_n),
        .enable_i  (accept),
        .bit_i     (bus.in_frame[0]),
        .clear_i   (bus.in_resync),
        .realign_i (realign),
        .shift_d_o (shift_d),
        .count_o   (bus.out_bit_count),
        .wrap_o    (wrap)
    );

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            ready_q   <= 1'b0;
            message_q <= '0;
            valid_q   <= 1'b0;
`ifdef STEGO_MATCH_EN
            match_q   <= 1'b0;
`endif
        end else begin
            frame_q <= bus.in_frame;
            ready_q <= bus.in_enable;
            valid_q <= wrap;
            if (wrap) begin
                message_q <= shift_d;
            end
`ifdef STEGO_MATCH_EN
            match_q <= match;
`endif
            if (bus.in_resync) begin
                state_q <= accept ? ST_COLLECT : ST_IDLE;
            end else if (wrap) begin
                state_q <= ST_EMIT;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (accept && !realign) begin
                            state_q <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (realign) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_EMIT: begin
                        state_q <= (accept && !realign) ? ST_COLLECT : ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.out_frame         = frame_q;
    assign bus.out_ready         = ready_q;
    assign bus.out_message       = message_q;
    assign bus.out_message_valid = valid_q;

endmodule

// File: tb/tb_stego_message_extractor.sv
// Randomized scoreboard bench for stego_message_extractor against a bit-queue reference model.
module tb_stego_message_extractor;
    import stego_pkg::*;

    localparam int unsigned BPS = BPS_DEFAULT;
    localparam int unsigned ML  = MESSAGE_LENGTH_DEFAULT;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    bit   mon_en   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    stego_message_extractor_if #(.BPS(BPS), .MESSAGE_LENGTH(ML)) bus ();

    stego_message_extractor #(
        .BPS            (BPS),
        .MESSAGE_LENGTH (ML)
    ) dut (
        .in_clk     (clk),
        .in_reset_n (rst_n),
        .bus        (bus)
    );

    // Reference model: bits collected since the last boundary, plus the expected outputs.
    bit            model_bits[$];
    logic [ML-1:0] window;
    logic [ML-1:0] exp_msg_q[$];
    int            exp_cyc_q[$];
    int            exp_count   = 0;
    int            match_cycle = -1;
    logic [ML-1:0] last_msg    = '0;
    logic [BPS-1:0] exp_frame  = '0;
    logic          exp_ready   = 1'b0;
    logic [ML-1:0] mon_msg;
    int            mon_cyc;
    logic [ML-1:0] default_msg;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic model_reset();
        model_bits.delete();
        window    = '0;
        exp_count = 0;
    endtask

    task automatic model_accept(input bit b, input bit resync);
        logic [ML-1:0] m;
        if (resync) begin
            model_bits.delete();
            window = '0;
        end
        model_bits.push_back(b);
        window = {window[ML-2:0], b};
        if (model_bits.size() == ML) begin
            m = '0;
            foreach (model_bits[i]) m = {m[ML-2:0], model_bits[i]};
            exp_msg_q.push_back(m);
            exp_cyc_q.push_back(cycle);
            model_bits.delete();
        end
`ifdef STEGO_MATCH_EN
        if (!resync && window == default_msg) begin
            match_cycle = cycle;
            model_bits.delete();
        end
`endif
        exp_count = model_bits.size();
    endtask

    // Called at posedge+1; the sample is taken by the next rising edge.
    task automatic drive_sample(input bit b, input bit resync, input int gap);
        logic [BPS-1:0] f;
        f    = BPS'($urandom);
        f[0] = b;
        bus.in_frame  = f;
        bus.in_enable = 1'b1;
        bus.in_resync = resync;
        @(posedge clk);
        #1;
        model_accept(b, resync);
        bus.in_enable = 1'b0;
        bus.in_resync = 1'b0;
        bus.in_frame  = BPS'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_message(input logic [ML-1:0] msg, input int max_gap);
        for (int i = ML - 1; i >= 0; i--) begin
            drive_sample(msg[i], 1'b0, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_frame <= '0;
            exp_ready <= 1'b0;
        end else begin
            exp_frame <= bus.in_frame;
            exp_ready <= bus.in_enable;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("bit_count", 128'(bus.out_bit_count), 128'(exp_count));
            check("out_frame", 128'(bus.out_frame), 128'(exp_frame));
            check("out_ready", 128'(bus.out_ready), 128'(exp_ready));
`ifdef STEGO_MATCH_EN
            check("out_match", 128'(bus.out_match), 128'(match_cycle == cycle));
`endif
            if (bus.out_message_valid) begin
                if (exp_msg_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid at cycle %0d: got valid, expected none", cycle);
                end else begin
                    mon_msg = exp_msg_q.pop_front();
                    mon_cyc = exp_cyc_q.pop_front();
                    check("message", 128'(bus.out_message), 128'(mon_msg));
                    check("valid_cycle", 128'(cycle), 128'(mon_cyc));
                    last_msg = mon_msg;
                end
            end else begin
                check("message_hold", 128'(bus.out_message), 128'(last_msg));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        default_msg = DEFAULT_MESSAGE;
`ifdef STEGO_MATCH_EN
        bus.in_expected = default_msg;
`endif
        bus.in_enable = 1'b0;
        bus.in_resync = 1'b0;
        bus.in_frame  = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_message", 128'(bus.out_message), 128'(0));
        check("reset_valid", 128'(bus.out_message_valid), 128'(0));
        check("reset_frame", 128'(bus.out_frame), 128'(0));
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single message with small random gaps.
        send_message(default_msg, 2);
        repeat (3) @(posedge clk);
        #1;
        check("msg1_value", 128'(bus.out_message), 128'(default_msg));

        // Two messages back-to-back at full rate.
        send_message(default_msg, 0);
        send_message(default_msg, 0);
        repeat (3) @(posedge clk);
        #1;

        // Resync with enable after 40 bits.
        for (int i = 0; i < 40; i++) drive_sample(1'($urandom), 1'b0, 0);
        drive_sample(1'($urandom), 1'b1, 0);
        check("resync_count", 128'(bus.out_bit_count), 128'(1));
        for (int i = 0; i < 87; i++) drive_sample(1'($urandom), 1'b0, int'($urandom_range(1, 0)));
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a message.
        for (int i = 0; i < 50; i++) drive_sample(1'($urandom), 1'b0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        last_msg = '0;
        #1;
        check("midrst_message", 128'(bus.out_message), 128'(0));
        check("midrst_count", 128'(bus.out_bit_count), 128'(0));
        check("midrst_frame", 128'(bus.out_frame), 128'(0));
        check("midrst_ready", 128'(bus.out_ready), 128'(0));
        check("midrst_valid", 128'(bus.out_message_valid), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_message(default_msg, 0);
        repeat (3) @(posedge clk);
        #1;
        check("postrst_value", 128'(bus.out_message), 128'(default_msg));

        // Widely spaced samples, including one very long gap.
        for (int i = ML - 1; i >= 0; i--) begin
            drive_sample(default_msg[i], 1'b0,
                         (i == 50) ? 20000 : int'($urandom_range(150, 20)));
        end
        repeat (3) @(posedge clk);
        #1;
        check("spaced_value", 128'(bus.out_message), 128'(default_msg));

`ifdef STEGO_MATCH_EN
        // Stream misaligned by 13 bits; the comparator realigns on the embedded message.
        drive_sample(1'($urandom), 1'b1, 0);
        for (int i = 0; i < 12; i++) drive_sample(1'($urandom), 1'b0, 0);
        send_message(default_msg, 0);
        send_message(default_msg, 0);
        repeat (3) @(posedge clk);
        #1;
        check("match_value", 128'(bus.out_message), 128'(default_msg));
`endif

        repeat (5) @(posedge clk);
        #1;
        check("pending_valid", 128'(exp_msg_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
